serial_word_feeder: RTL and testbench
=====================================

# serial_word_feeder

Upstream stage for the serial sequence detector. Accepts parallel words over a valid/ready handshake, buffers one word, and shifts each word out one bit per clock on `xout`, which drives the detector's serial input. Back-to-back words stream with no idle gap. A 10-bit counter of completed words lets the bench cross-check the detector's match count.

## Interface
- `WIDTH`, 8: bits per word. Legal range is 2..32.
- `MSB_FIRST`, 1: 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.
- `IDLE_BIT`, 1'b1: level driven on `xout` when no word is shifting.

- `clk`  in  1  single clock, rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept a word.
- `xout`  out  1  serial bit, registered.
- `xout_valid`  out  1  `xout` carries a word bit this cycle.
- `busy`  out  1  shifter active or hold register full.
- `words_sent`  out  10  count of fully emitted words, wraps.

## Operation
- **Storage:** hold register (`hold`, `hold_full`), shift register (`sreg`), and bit counter `bcnt` (width clog2(WIDTH)).
- **States:**
  - IDLE: `xout = IDLE_BIT`, `xout_valid = 0`.
  - SHIFT: emits one bit per cycle.
- **Accept:** `din_ready = ~hold_full`. Combinational from the register, never from `din_valid`. A word is accepted on a rising edge with `din_valid & din_ready`; it loads `hold` and sets `hold_full`.
- **Transfer:**
  - Condition: `hold_full` and (state is IDLE, or state is SHIFT with `bcnt == WIDTH-1`).
  - Actions, all on the same edge:
    - `hold` moves into `sreg`.
    - The first bit goes to `xout`.
    - `xout_valid = 1`, `bcnt = 0`, state becomes SHIFT.
    - `hold_full` clears, unless an accept happens on the same edge, in which case it stays 1 with the new word.
- **Shift:** in SHIFT with `bcnt < WIDTH-1`, each edge drives the next bit and increments `bcnt`. Bit order is set by `MSB_FIRST`.
- **End of word:** in SHIFT with `bcnt == WIDTH-1` and no transfer, the next edge goes to IDLE. That edge sets `xout = IDLE_BIT` and `xout_valid = 0`.
- **`words_sent`:**
  - Increments by 1 on every edge that leaves a word's last bit, i.e. any edge taken from SHIFT with `bcnt == WIDTH-1`, whether the next state is IDLE or a back-to-back transfer.
  - Modulo 1024: 1023 wraps to 0.
- **`busy`:** `(state == SHIFT) | hold_full`.
- **`din` stability:** `din` is sampled only on the accept edge; it may change at any time otherwise.

## Timing
- **Reset values:** while `rstn = 0`:
  - `xout = IDLE_BIT`, `xout_valid = 0`
  - state IDLE, `hold_full = 0` so `din_ready = 1`
  - `busy = 0`, `words_sent = 0`
- **Accept is gated by reset:** an accept needs `rstn = 1` at the edge.
- **Mid-operation reset:** clears everything immediately. A partial word and any held word are discarded and not counted.
- **Latency, empty block:** accept at edge E0, transfer at E1. `xout` shows bit 0 of the stream order from E1 to E2. The last bit is shown from E(WIDTH) to E(WIDTH+1).
- **Streaming throughput:**
  - After a transfer, `din_ready` is 1 from the next cycle on.
  - A word accepted at any edge up to and including the last-bit edge of the current word is transferred back-to-back.
  - `xout_valid` stays 1 continuously, at one word per WIDTH cycles.
- **Simultaneous accept and transfer:** both take effect on the same edge with no loss. The new word lands in `hold` while the old word moves to `sreg`.
- **Held-off valid:** `din_valid` held high while `din_ready = 0` is not an accept. The word is accepted on the first edge where `din_ready = 1`.

## Test plan
- **Reset:** `rstn` low for 5 cycles, then high, no `din_valid` → `xout = 1`, `xout_valid = 0`, `din_ready = 1`, `busy = 0`, `words_sent = 0` throughout.
- **Single word, MSB first:** `din = 8'h4A`, valid for one edge → starting one cycle after accept, `xout` = 0,1,0,0,1,0,1,0 with `xout_valid = 1` for exactly 8 cycles. Then `xout = 1`, `xout_valid = 0`, `words_sent = 1`.
- **Streaming:** `din_valid` held high with 4 words `8'h49, 8'h24, 8'h92, 8'h49` → `xout_valid` high for exactly 32 consecutive cycles with bits concatenated MSB-first and no gap. `din_ready` is low whenever `hold_full`. `words_sent = 4`.
- **Mid-word reset:** start `8'hFF`, assert `rstn = 0` after 3 bits → `xout` returns to 1 asynchronously, `xout_valid = 0`, `words_sent = 0`. The next word after release is emitted cleanly from its first bit.
- **LSB first:** set `MSB_FIRST = 0` and `WIDTH = 4`, send `din = 4'b0010` → `xout` = 0,1,0,0.
- **Counter wrap:** send 1025 back-to-back words of `8'h00` → `words_sent` reads 1023 after word 1023, 0 after word 1024, 1 after word 1025.

Source files
------------

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts parallel words over valid/ready, buffers one
// word in a hold register and serialises each word onto xout, one bit per
// clock, with back-to-back words streaming without an idle gap.
//
// Ports:
//   clk        - rising-edge clock
//   rstn       - asynchronous active-low reset
//   din        - parallel input word (WIDTH bits)
//   din_valid  - din carries a word
//   din_ready  - hold register empty, a word can be accepted
//   xout       - registered serial bit (IDLE_BIT when not shifting)
//   xout_valid - xout carries a word bit this cycle
//   busy       - shifter active or hold register full
//   words_sent - count of fully emitted words, wraps modulo 1024
module serial_word_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             xout,
  output logic             xout_valid,
  output logic             busy,
  output logic [9:0]       words_sent
);

  localparam int unsigned BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW   = 10;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bcnt;

  logic             accept;
  logic             last_bit;
  logic             transfer;
  logic             hold_first;
  logic [WIDTH-1:0] hold_rest;
  logic             sreg_next;
  logic [WIDTH-1:0] sreg_rest;

  // Handshake and word-boundary decode
  always_comb begin
    accept   = din_valid & ~hold_full;
    last_bit = (state_q == SHIFT) && (bcnt == LAST);
    transfer = hold_full && ((state_q == IDLE) || last_bit);
  end

  // Bit-order selection; sreg is kept pre-advanced so its head is the next bit
  always_comb begin
    if (MSB_FIRST) begin
      hold_first = hold[WIDTH-1];
      hold_rest  = hold << 1;
      sreg_next  = sreg[WIDTH-1];
      sreg_rest  = sreg << 1;
    end else begin
      hold_first = hold[0];
      hold_rest  = hold >> 1;
      sreg_next  = sreg[0];
      sreg_rest  = sreg >> 1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (transfer) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_bit && !transfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold register: accept and transfer may coincide without losing a word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) hold <= din;
      hold_full <= accept | (hold_full & ~transfer);
    end
  end

  // Shifter and registered serial output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sreg       <= '0;
      bcnt       <= '0;
      xout       <= IDLE_BIT;
      xout_valid <= 1'b0;
    end else if (transfer) begin
      sreg       <= hold_rest;
      bcnt       <= '0;
      xout       <= hold_first;
      xout_valid <= 1'b1;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        xout       <= IDLE_BIT;
        xout_valid <= 1'b0;
      end else begin
        sreg       <= sreg_rest;
        bcnt       <= bcnt + BW'(1);
        xout       <= sreg_next;
        xout_valid <= 1'b1;
      end
    end
  end

  // Completed-word counter, bumped on the edge that leaves a word's last bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      words_sent <= '0;
    end else if (last_bit) begin
      words_sent <= CW'(words_sent + CW'(1));
    end
  end

  assign din_ready = ~hold_full;
  assign busy      = (state_q == SHIFT) | hold_full;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed self-checking bench for serial_word_feeder: an 8-bit MSB-first
// instance covers reset, latency, streaming, mid-word reset and counter wrap;
// a 4-bit LSB-first instance covers bit order.
module tb_serial_word_feeder;

  logic       clk;
  logic       rstn;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       xout;
  logic       xout_valid;
  logic       busy;
  logic [9:0] words_sent;

  logic [3:0] din4;
  logic       valid4;
  logic       ready4;
  logic       xout4;
  logic       xvalid4;
  logic       busy4;
  logic [9:0] words4;

  int n_cmp = 0;
  int n_bad = 0;

  logic bitq[$];
  int   run = 0;
  int   last_run = 0;

  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .xout(xout), .xout_valid(xout_valid),
    .busy(busy), .words_sent(words_sent)
  );

  serial_word_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut4 (
    .clk(clk), .rstn(rstn), .din(din4), .din_valid(valid4),
    .din_ready(ready4), .xout(xout4), .xout_valid(xvalid4),
    .busy(busy4), .words_sent(words4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every valid serial bit and the length of the last valid run
  initial begin
    forever begin
      @(negedge clk);
      if (xout_valid) begin
        bitq.push_back(xout);
        run = run + 1;
      end else begin
        if (run != 0) last_run = run;
        run = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Present a word and return 1 time unit after the edge that accepts it
  task automatic send(input logic [7:0] w);
    int n;
    din       = w;
    din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 100) begin
      tick();
      n = n + 1;
    end
    if (n >= 100) check("ready_timeout", 32'(din_ready), 32'd1);
    tick();
  endtask

  // Pack n recorded bits starting at index base, first bit in the MSB
  function automatic logic [31:0] gather(input int base, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w = (w << 1) | 32'(bitq[base + i]);
    return w;
  endfunction

  initial begin
    int base;
    int c;
    int cyc;
    bit seen1023;
    bit seen1024;

    rstn      = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    din4      = '0;
    valid4    = 1'b0;

    // Reset: 5 cycles low, then idle with no valid
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_xout",  32'(xout),       32'd1);
      check("rst_xvld",  32'(xout_valid), 32'd0);
      check("rst_ready", 32'(din_ready),  32'd1);
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_words", 32'(words_sent), 32'd0);
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_xout",  32'(xout),       32'd1);
      check("idle_xvld",  32'(xout_valid), 32'd0);
      check("idle_busy",  32'(busy),       32'd0);
      check("idle_words", 32'(words_sent), 32'd0);
    end

    // Single word 8'h4A, MSB first, one-cycle transfer latency
    base = bitq.size();
    send(8'h4A);
    din_valid = 1'b0;
    check("lat_xvld_e0", 32'(xout_valid), 32'd0);
    check("lat_busy_e0", 32'(busy),       32'd1);
    check("lat_rdy_e0",  32'(din_ready),  32'd0);
    tick();
    check("lat_xvld_e1", 32'(xout_valid), 32'd1);
    check("lat_xout_e1", 32'(xout),       32'd0);
    check("lat_rdy_e1",  32'(din_ready),  32'd1);
    repeat (11) tick();
    check("w4a_nbits", 32'(bitq.size() - base), 32'd8);
    check("w4a_bits",  gather(base, 8),         32'h4A);
    check("w4a_run",   32'(last_run),           32'd8);
    check("w4a_xout",  32'(xout),               32'd1);
    check("w4a_xvld",  32'(xout_valid),         32'd0);
    check("w4a_words", 32'(words_sent),         32'd1);
    check("w4a_busy",  32'(busy),               32'd0);

    // Streaming: four words with din_valid held high, no gap
    do_reset();
    base = bitq.size();
    send(8'h49);
    send(8'h24);
    check("str_ready_full", 32'(din_ready), 32'd0);
    check("str_busy_full",  32'(busy),      32'd1);
    send(8'h92);
    send(8'h49);
    din_valid = 1'b0;
    repeat (20) tick();
    check("str_nbits", 32'(bitq.size() - base), 32'd32);
    check("str_bits",  gather(base, 32),        32'h49249249);
    check("str_run",   32'(last_run),           32'd32);
    check("str_words", 32'(words_sent),         32'd4);

    // Mid-word asynchronous reset, then a clean word
    do_reset();
    send(8'hFF);
    din_valid = 1'b0;
    repeat (3) tick();
    check("mrst_xvld_pre", 32'(xout_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_xout",  32'(xout),       32'd1);
    check("mrst_xvld",  32'(xout_valid), 32'd0);
    check("mrst_words", 32'(words_sent), 32'd0);
    check("mrst_busy",  32'(busy),       32'd0);
    check("mrst_ready", 32'(din_ready),  32'd1);
    tick();
    rstn = 1'b1;
    repeat (2) tick();
    check("mrst_idle_xvld", 32'(xout_valid), 32'd0);
    base = bitq.size();
    send(8'hA5);
    din_valid = 1'b0;
    repeat (12) tick();
    check("mrst_nbits", 32'(bitq.size() - base), 32'd8);
    check("mrst_bits",  gather(base, 8),         32'hA5);
    check("mrst_run",   32'(last_run),           32'd8);
    check("mrst_words2", 32'(words_sent),        32'd1);

    // LSB-first 4-bit instance: 4'b0010 emits 0,1,0,0
    do_reset();
    din4   = 4'b0010;
    valid4 = 1'b1;
    check("lsb_ready", 32'(ready4), 32'd1);
    tick();
    valid4 = 1'b0;
    check("lsb_xvld_e0", 32'(xvalid4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] ref_w;
      ref_w = 4'b0010;
      tick();
      check("lsb_xvld", 32'(xvalid4), 32'd1);
      check("lsb_bit",  32'(xout4),   32'(ref_w[i]));
    end
    tick();
    check("lsb_end_xvld", 32'(xvalid4), 32'd0);
    check("lsb_end_xout", 32'(xout4),   32'd1);
    check("lsb_words",    32'(words4),  32'd1);

    // Counter wrap: 1025 back-to-back zero words
    do_reset();
    base     = bitq.size();
    seen1023 = 1'b0;
    seen1024 = 1'b0;
    fork
      begin
        for (int k = 0; k < 1025; k++) send(8'h00);
        din_valid = 1'b0;
      end
    join_none
    cyc = 0;
    c   = 0;
    while (c < 1025 && cyc < 9000) begin
      tick();
      cyc = cyc + 1;
      c = (bitq.size() - base) / 8;
      if (c == 1023 && !seen1023) begin
        seen1023 = 1'b1;
        check("wrap_1023", 32'(words_sent), 32'd1023);
      end
      if (c == 1024 && !seen1024) begin
        seen1024 = 1'b1;
        check("wrap_1024", 32'(words_sent), 32'd0);
      end
      if (c == 1025) check("wrap_1025", 32'(words_sent), 32'd1);
    end
    if (cyc >= 9000) check("wrap_timeout", 32'(c), 32'd1025);
    repeat (5) tick();
    check("wrap_seen", 32'({seen1023, seen1024}), 32'd3);
    check("wrap_run",  32'(last_run),             32'd8200);
    check("wrap_idle", 32'(xout_valid),           32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
